// File: rtl/mips_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_ctrl_pkg: opcode, ALUOp and control-bundle definitions for ID/EX.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_LWSW  = 2'b00;
   localparam logic [1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_UNK   = 2'b11;

   typedef struct packed {
      logic reg_dst;
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
      logic branch;
   } ctrl_t;

   localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

`default_nettype wire

// File: rtl/id_main_decoder.sv
// +--------------------------------------------------------------------------+
// | id_main_decoder: opcode -> control bundle, ALUOp, rt-usage, illegal flag. |
// | Optional addi decode under IDEX_ADDI_EN.  Rev 1.0                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_main_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   output ctrl_t      ctrl_o,
   output logic [1:0] alu_op_o,
   output logic       uses_rt_o,
   output logic       illegal_o
);

   always_comb begin
      ctrl_o    = BUBBLE_CTRL;
      alu_op_o  = ALUOP_UNK;
      uses_rt_o = 1'b0;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            alu_op_o         = ALUOP_RTYPE;
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            uses_rt_o        = 1'b1;
         end
         OP_LW: begin
            alu_op_o          = ALUOP_LWSW;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
         end
         OP_SW: begin
            alu_op_o         = ALUOP_LWSW;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            uses_rt_o        = 1'b1;
         end
         OP_BEQ: begin
            alu_op_o      = ALUOP_BEQ;
            ctrl_o.branch = 1'b1;
            uses_rt_o     = 1'b1;
         end
`ifdef IDEX_ADDI_EN
         // rt is the destination of addi, so it never feeds the hazard compare
         OP_ADDI: begin
            alu_op_o         = ALUOP_LWSW;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
`endif
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_control_stage.sv
// +--------------------------------------------------------------------------+
// | id_ex_control_stage: ID decode, load-use hazard, flush/hold, ID/EX regs.  |
// | IDEX_ADDI_EN enables addi decode.  Rev 1.0                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_ex_control_stage
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
)(
   input  logic              Clk,
   input  logic              Reset_L,
   input  logic [DATA_W-1:0] Instruction_ID,
   input  logic              Hold_ID,
   input  logic              Flush_ID,
   output logic              Stall_ID,
   output logic [1:0]        ALUOp_EX,
   output logic [DATA_W-1:0] Sign_Extend_Instruction_EX,
   output logic              RegDst_EX,
   output logic              ALUSrc_EX,
   output logic              MemRead_EX,
   output logic              MemWrite_EX,
   output logic              MemtoReg_EX,
   output logic              RegWrite_EX,
   output logic              Branch_EX,
   output logic [REG_W-1:0]  Rs_EX,
   output logic [REG_W-1:0]  Rt_EX,
   output logic [REG_W-1:0]  Rd_EX,
   output logic              Valid_EX,
   output logic              Illegal_EX
);

   ctrl_t              w_ctrl;
   logic [1:0]         w_alu_op;
   logic               w_uses_rt;
   logic               w_illegal;
   logic [REG_W-1:0]   w_rs;
   logic [REG_W-1:0]   w_rt;
   logic [REG_W-1:0]   w_rd;
   logic [DATA_W-1:0]  w_imm;
   logic               w_bubble;

   ctrl_t              ctrl_q,      ctrl_d;
   logic [1:0]         alu_op_q,    alu_op_d;
   logic               valid_q,     valid_d;
   logic               illegal_q,   illegal_d;
   logic [REG_W-1:0]   rs_q,        rs_d;
   logic [REG_W-1:0]   rt_q,        rt_d;
   logic [REG_W-1:0]   rd_q,        rd_d;
   logic [DATA_W-1:0]  imm_q,       imm_d;
   logic               flush_pend_q, flush_pend_d;

   id_main_decoder u_dec (
      .opcode_i  (Instruction_ID[31:26]),
      .ctrl_o    (w_ctrl),
      .alu_op_o  (w_alu_op),
      .uses_rt_o (w_uses_rt),
      .illegal_o (w_illegal)
   );

   assign w_rs  = Instruction_ID[21 +: REG_W];
   assign w_rt  = Instruction_ID[16 +: REG_W];
   assign w_rd  = Instruction_ID[11 +: REG_W];
   assign w_imm = {{(DATA_W-16){Instruction_ID[15]}}, Instruction_ID[15:0]};

   // Evaluated from the EX registers even while held, so a frozen lw keeps stalling
   assign Stall_ID = valid_q & ctrl_q.mem_read & (rt_q != '0) &
                     ((rt_q == w_rs) | ((rt_q == w_rt) & w_uses_rt));

   assign w_bubble = Flush_ID | flush_pend_q | Stall_ID;

   always_comb begin
      ctrl_d       = ctrl_q;
      alu_op_d     = alu_op_q;
      valid_d      = valid_q;
      illegal_d    = illegal_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      rd_d         = rd_q;
      imm_d        = imm_q;
      flush_pend_d = flush_pend_q;
      if (Hold_ID) begin
         flush_pend_d = flush_pend_q | Flush_ID;
      end else begin
         flush_pend_d = 1'b0;
         if (w_bubble) begin
            ctrl_d    = BUBBLE_CTRL;
            alu_op_d  = ALUOP_UNK;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            imm_d     = '0;
         end else begin
            ctrl_d    = w_ctrl;
            alu_op_d  = w_alu_op;
            valid_d   = 1'b1;
            illegal_d = w_illegal;
            rs_d      = w_rs;
            rt_d      = w_rt;
            rd_d      = w_rd;
            imm_d     = w_imm;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         ctrl_q       <= BUBBLE_CTRL;
         alu_op_q     <= ALUOP_UNK;
         valid_q      <= 1'b0;
         illegal_q    <= 1'b0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         imm_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         ctrl_q       <= ctrl_d;
         alu_op_q     <= alu_op_d;
         valid_q      <= valid_d;
         illegal_q    <= illegal_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         imm_q        <= imm_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign ALUOp_EX                   = alu_op_q;
   assign Sign_Extend_Instruction_EX = imm_q;
   assign RegDst_EX                  = ctrl_q.reg_dst;
   assign ALUSrc_EX                  = ctrl_q.alu_src;
   assign MemRead_EX                 = ctrl_q.mem_read;
   assign MemWrite_EX                = ctrl_q.mem_write;
   assign MemtoReg_EX                = ctrl_q.mem_to_reg;
   assign RegWrite_EX                = ctrl_q.reg_write;
   assign Branch_EX                  = ctrl_q.branch;
   assign Rs_EX                      = rs_q;
   assign Rt_EX                      = rt_q;
   assign Rd_EX                      = rd_q;
   assign Valid_EX                   = valid_q;
   assign Illegal_EX                 = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_control_stage.sv
// +--------------------------------------------------------------------------+
// | tb_id_ex_control_stage: directed + random bench with behavioural model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_control_stage;

   logic        Clk = 1'b0;
   logic        Reset_L;
   logic [31:0] Instruction_ID;
   logic        Hold_ID;
   logic        Flush_ID;
   logic        Stall_ID;
   logic [1:0]  ALUOp_EX;
   logic [31:0] Sign_Extend_Instruction_EX;
   logic        RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX, Branch_EX;
   logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
   logic        Valid_EX, Illegal_EX;

   id_ex_control_stage #(.DATA_W(32), .REG_W(5)) u_dut (
      .Clk                        (Clk),
      .Reset_L                    (Reset_L),
      .Instruction_ID             (Instruction_ID),
      .Hold_ID                    (Hold_ID),
      .Flush_ID                   (Flush_ID),
      .Stall_ID                   (Stall_ID),
      .ALUOp_EX                   (ALUOp_EX),
      .Sign_Extend_Instruction_EX (Sign_Extend_Instruction_EX),
      .RegDst_EX                  (RegDst_EX),
      .ALUSrc_EX                  (ALUSrc_EX),
      .MemRead_EX                 (MemRead_EX),
      .MemWrite_EX                (MemWrite_EX),
      .MemtoReg_EX                (MemtoReg_EX),
      .RegWrite_EX                (RegWrite_EX),
      .Branch_EX                  (Branch_EX),
      .Rs_EX                      (Rs_EX),
      .Rt_EX                      (Rt_EX),
      .Rd_EX                      (Rd_EX),
      .Valid_EX                   (Valid_EX),
      .Illegal_EX                 (Illegal_EX)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Expected decode table, controls ordered {RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite,Branch}
   typedef struct packed {
      logic [1:0] aluop;
      logic [6:0] ctl;
      logic       illegal;
      logic       uses_rt;
   } dec_t;

   function automatic dec_t ref_decode(input logic [5:0] op);
      case (op)
         6'b000000: return '{2'b10, 7'b1000010, 1'b0, 1'b1};
         6'b100011: return '{2'b00, 7'b0110110, 1'b0, 1'b0};
         6'b101011: return '{2'b00, 7'b0101000, 1'b0, 1'b1};
         6'b000100: return '{2'b01, 7'b0000001, 1'b0, 1'b1};
`ifdef IDEX_ADDI_EN
         6'b001000: return '{2'b00, 7'b0100010, 1'b0, 1'b0};
`endif
         default:   return '{2'b11, 7'b0000000, 1'b1, 1'b0};
      endcase
   endfunction

   // Reference EX-stage contents
   logic [1:0]  m_aluop;
   logic [6:0]  m_ctl;
   logic        m_valid, m_ill, m_pend;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [31:0] m_imm;
   logic        last_stall;

   task automatic m_empty();
      m_aluop = 2'b11; m_ctl = '0; m_valid = 0; m_ill = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0;
   endtask

   task automatic step(input logic [31:0] ins, input logic hold, input logic flush, input logic rstl);
      dec_t d;
      logic stall_exp;
      Instruction_ID = ins; Hold_ID = hold; Flush_ID = flush; Reset_L = rstl;
      #1;
      d = ref_decode(ins[31:26]);
      stall_exp = m_valid && m_ctl[4] && (m_rt != 0) &&
                  ((m_rt == ins[25:21]) || (d.uses_rt && (m_rt == ins[20:16])));
      last_stall = Stall_ID;
      chk("stall", {63'd0, Stall_ID}, {63'd0, stall_exp});
      if (!rstl) begin
         m_empty(); m_pend = 0;
      end else if (hold) begin
         m_pend = m_pend | flush;
      end else if (flush || m_pend || stall_exp) begin
         m_empty(); m_pend = 0;
      end else begin
         m_aluop = d.aluop; m_ctl = d.ctl; m_valid = 1; m_ill = d.illegal;
         m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
         m_imm = 32'(signed'(ins[15:0]));
         m_pend = 0;
      end
      @(posedge Clk);
      #1;
      chk("ex_ctl",
          {38'd0, ALUOp_EX, RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX,
           RegWrite_EX, Branch_EX, Valid_EX, Illegal_EX, Rs_EX, Rt_EX, Rd_EX},
          {38'd0, m_aluop, m_ctl, m_valid, m_ill, m_rs, m_rt, m_rd});
      chk("ex_imm", {32'd0, Sign_Extend_Instruction_EX}, {32'd0, m_imm});
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [6];
      logic [5:0] op;
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
      ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'($urandom);
      op = ops[$urandom_range(0, 5)];
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
   endfunction

   localparam logic [31:0] ADD_A = 32'h00221820;  // add $3,$1,$2
   localparam logic [31:0] LW_A  = 32'h8C22FFFC;  // lw  $2,-4($1)
   localparam logic [31:0] ADD_B = 32'h00441820;  // add $3,$2,$4
   localparam logic [31:0] BEQ_A = 32'h10220003;
   localparam logic [31:0] ADDI  = 32'h20220005;

   initial begin
      m_empty(); m_pend = 0; last_stall = 0;
      Reset_L = 0; Hold_ID = 0; Flush_ID = 0; Instruction_ID = 0;
      @(posedge Clk);
      #1;

      step(32'h0, 0, 0, 0);
      step(32'h0, 0, 0, 0);
      chk("rst_aluop", {62'd0, ALUOp_EX}, 64'd3);
      chk("rst_valid", {63'd0, Valid_EX}, 64'd0);

      step(ADD_A, 0, 0, 1);
      chk("add_aluop", {62'd0, ALUOp_EX}, 64'd2);
      chk("add_funct", {58'd0, Sign_Extend_Instruction_EX[5:0]}, 64'h20);
      chk("add_rd", {59'd0, Rd_EX}, 64'd3);

      step(LW_A, 0, 0, 1);
      chk("lw_imm", {32'd0, Sign_Extend_Instruction_EX}, 64'hFFFFFFFC);
      step(ADD_B, 0, 0, 1);
      chk("lu_stall", {63'd0, last_stall}, 64'd1);
      chk("lu_bubble", {63'd0, Valid_EX}, 64'd0);
      step(ADD_B, 0, 0, 1);
      chk("lu_stall_once", {63'd0, last_stall}, 64'd0);
      chk("lu_add_ex", {59'd0, Rt_EX}, 64'd4);

      step(ADD_A, 1, 0, 1);
      step(ADD_A, 1, 1, 1);
      step(ADD_A, 1, 0, 1);
      chk("hold_frozen", {59'd0, Rt_EX}, 64'd4);
      step(ADD_A, 0, 0, 1);
      chk("hold_flush_bubble", {63'd0, Valid_EX}, 64'd0);
      step(ADD_A, 0, 0, 1);
      chk("after_pend_load", {63'd0, Valid_EX}, 64'd1);

      step(BEQ_A, 0, 1, 1);
      chk("beq_flush_branch", {63'd0, Branch_EX}, 64'd0);
      chk("beq_flush_aluop", {62'd0, ALUOp_EX}, 64'd3);

      step(ADDI, 0, 0, 1);
`ifdef IDEX_ADDI_EN
      chk("addi_aluop", {62'd0, ALUOp_EX}, 64'd0);
      chk("addi_alusrc", {63'd0, ALUSrc_EX}, 64'd1);
      chk("addi_imm", {32'd0, Sign_Extend_Instruction_EX}, 64'd5);
`else
      chk("addi_illegal", {63'd0, Illegal_EX}, 64'd1);
      chk("addi_aluop", {62'd0, ALUOp_EX}, 64'd3);
`endif

      for (int i = 0; i < 600; i++) begin
         step(rand_instr(),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 63) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
